// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants and controller state encoding
package aes_pkg;

    localparam int unsigned AES_DW = 128;
    localparam logic [3:0]  AES_NR = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/aes_iter_ctrl_round.sv
// rtl/aes_iter_ctrl_round.sv - combinational AES-128 round and on-the-fly key expansion step
module round
    import aes_pkg::*;
(
    input  logic [AES_DW-1:0] in_i,
    input  logic [AES_DW-1:0] keyin_i,
    input  logic [3:0]        round_num_i,
    output logic [AES_DW-1:0] out_o,
    output logic [AES_DW-1:0] keyout_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as the GF(2^8) inverse (b^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [127:0] sr;
    logic [127:0] mc;
    logic [31:0]  w0, w1, w2, w3, tw;
    logic [7:0]   rcon;
    logic [7:0]   a0, a1, a2, a3;
    int           src;

    always_comb begin
        sr  = '0;
        mc  = '0;
        src = 0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        a3  = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            sr[127-8*i -: 8] = sbox(in_i[127-8*src -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            mc[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        // Final round skips MixColumns.
        if (round_num_i == AES_NR) mc = sr;
    end

    always_comb begin
        case (round_num_i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        w0 = keyin_i[127:96] ^ tw;
        w1 = keyin_i[95:64] ^ w0;
        w2 = keyin_i[63:32] ^ w1;
        w3 = keyin_i[31:0] ^ w2;
    end

    assign tw = {sbox(keyin_i[23:16]) ^ rcon, sbox(keyin_i[15:8]),
                 sbox(keyin_i[7:0]), sbox(keyin_i[31:24])};

    assign keyout_o = {w0, w1, w2, w3};
    assign out_o    = mc ^ keyout_o;

endmodule

// File: rtl/aes_iter_ctrl.sv
// rtl/aes_iter_ctrl.sv - iterative AES-128 encryption controller with stored master key
module aes_iter_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AES_DW-1:0] in_data,
    input  logic [AES_DW-1:0] in_key,
    input  logic              in_key_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AES_DW-1:0] out_data,
    output logic              busy,
    output logic [3:0]        round_cnt
);

    state_e            st_q, st_d;
    logic [AES_DW-1:0] data_q, data_d;
    logic [AES_DW-1:0] key_q, key_d;
    logic [AES_DW-1:0] mkey_q, mkey_d;
    logic [AES_DW-1:0] out_data_q, out_data_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [AES_DW-1:0] sel_key;
    logic [AES_DW-1:0] dp_out, dp_keyout;

    round u_round (
        .in_i        (data_q),
        .keyin_i     (key_q),
        .round_num_i (rcnt_q),
        .out_o       (dp_out),
        .keyout_o    (dp_keyout)
    );

    assign sel_key = in_key_load ? in_key : mkey_q;

    always_comb begin
        st_d       = st_q;
        data_d     = data_q;
        key_d      = key_q;
        mkey_d     = mkey_q;
        out_data_d = out_data_q;
        rcnt_d     = rcnt_q;
        case (st_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = in_data ^ sel_key;
                    key_d  = sel_key;
                    if (in_key_load) mkey_d = in_key;
                    rcnt_d = 4'd1;
                    st_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = dp_out;
                key_d  = dp_keyout;
                if (rcnt_q == AES_NR) begin
                    out_data_d = dp_out;
                    rcnt_d     = 4'd0;
                    st_d       = ST_DONE;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_IDLE;
            data_q     <= '0;
            key_q      <= '0;
            mkey_q     <= '0;
            out_data_q <= '0;
            rcnt_q     <= 4'd0;
        end else begin
            st_q       <= st_d;
            data_q     <= data_d;
            key_q      <= key_d;
            mkey_q     <= mkey_d;
            out_data_q <= out_data_d;
            rcnt_q     <= rcnt_d;
        end
    end

    // Handshake outputs decode the state register only, so no combinational path from out_ready.
    assign in_ready  = (st_q == ST_IDLE);
    assign out_valid = (st_q == ST_DONE);
    assign busy      = (st_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign round_cnt = rcnt_q;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// tb/tb_aes_iter_ctrl.sv - randomized self-checking bench for aes_iter_ctrl against a byte-level AES model
module tb_aes_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_key_load;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   round_cnt;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   sb_tab [256];
    logic [127:0] mkey_m;

    aes_iter_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .in_key_load (in_key_load),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .round_cnt   (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = 8'h63;
            for (int k = 0; k < 8; k++)
                sb_tab[x][k] = 8'h63 >> k & 1 ^ inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8]
                               ^ inv[(k+6)%8] ^ inv[(k+7)%8];
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   x0;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x0 = tmp[0];
                tmp[0] = sb_tab[tmp[1]] ^ rc;
                tmp[1] = sb_tab[tmp[2]];
                tmp[2] = sb_tab[tmp[3]];
                tmp[3] = sb_tab[x0];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++)
                t[i] = sb_tab[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        while (in_ready !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", {127'd0, in_ready}, 128'd1);
    endtask

    task automatic accept(input logic [127:0] pt, input logic [127:0] key, input bit load);
        wait_idle();
        in_valid    = 1'b1;
        in_data     = pt;
        in_key      = key;
        in_key_load = load;
        @(posedge clk);
        if (load) mkey_m = key;
        @(negedge clk);
        in_valid    = 1'b0;
        in_key_load = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input bit load,
                             input logic [127:0] exp, input int hold);
        out_ready = (hold == 0);
        accept(pt, key, load);
        for (int k = 1; k <= 10; k++) begin
            check("round_cnt", 128'(round_cnt), 128'(k));
            check("ovalid_run", 128'(out_valid), 128'd0);
            @(negedge clk);
        end
        check("ovalid_done", 128'(out_valid), 128'd1);
        check("rcnt_done", 128'(round_cnt), 128'd0);
        check("out_data", out_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_data", out_data, exp);
            check("bp_ready", 128'({in_ready, busy}), 128'b01);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_idle", 128'({in_ready, out_valid, busy}), 128'b100);
        check("post_data", out_data, exp);
    endtask

    initial begin
        logic [127:0] pt, key, exp;
        bit           ld;
        int           accepts[$];
        int           t;

        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, key, exp;
        bit           ld;
        int           acc[$];
        int           t;

        build_sbox();
        mkey_m      = '0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_key      = '0;
        in_key_load = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_state", 128'({in_ready, out_valid, busy, round_cnt}), 128'b1000000);
        check("rst_data", out_data, 128'd0);

        run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1,
                  128'h3925841d02dc09fbdc118597196a0b32, 0);
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
        run_block(128'h00112233445566778899aabbccddeeff, {128{1'b1}}, 1'b0,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, key, 1'b1, aes_ref(pt, key), 20);

        out_ready = 1'b1;
        accept(pt ^ 128'h1, key, 1'b1);
        t = 0;
        while (round_cnt !== 4'd5 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_rcnt", 128'(round_cnt), 128'd5);
        #1 rst = 1'b1;
        #1;
        check("mid_rst", 128'({out_valid, busy, round_cnt}), 128'd0);
        check("mid_rst_data", out_data, 128'd0);
        @(negedge clk);
        rst    = 1'b0;
        mkey_m = '0;
        @(negedge clk);
        run_block(128'd0, {128{1'b1}}, 1'b0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 0);

        for (int n = 0; n < 8; n++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            ld  = ($urandom_range(0, 2) != 0);
            exp = aes_ref(pt, ld ? key : mkey_m);
            run_block(pt, key, ld, exp, int'($urandom_range(0, 3)));
        end

        wait_idle();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_key_load = 1'b1;
        in_data     = 128'h00112233445566778899aabbccddeeff;
        in_key      = 128'h000102030405060708090a0b0c0d0e0f;
        for (int cyc = 0; cyc < 50; cyc++) begin
            check("ready_vs_busy", 128'(in_ready), 128'(!busy));
            if (in_ready) acc.push_back(cyc);
            @(negedge clk);
        end
        in_valid    = 1'b0;
        in_key_load = 1'b0;
        check("accept_count", 128'(acc.size()), 128'd5);
        for (int i = 1; i < acc.size(); i++)
            check("accept_spacing", 128'(acc[i] - acc[i-1]), 128'd12);
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("cont_data", out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_iter_ctrl.md
Name: aes_iter_ctrl

Overview:
Iterative AES-128 encryption controller. It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then drives one combinational round datapath (`round`) for rounds 1..10, one round per clock, and presents the ciphertext over a valid/ready output handshake. It sits between the host-side block source (the Pass-Keeper record encryptor) and the AES round logic, and it holds the master key so that consecutive blocks can reuse it.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; width of round_cnt is fixed at 4.
- DW, 128, data/key width; fixed at 128.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext (and optional key) presented.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_data  in  128  plaintext block.
- in_key  in  128  cipher key; sampled only when in_key_load=1.
- in_key_load  in  1  1 = load in_key as master key; 0 = reuse stored master key.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext; holds last value until next completion.
- busy  out  1  high in RUN or DONE.
- round_cnt  out  4  current round index driven to the datapath (0 in IDLE).

Behaviour:
- Reset (async, immediate): state=IDLE; state_reg, key_reg, mkey_reg and out_data all 0; round_cnt=0; out_valid=0; busy=0; in_ready=1 once rst deasserts.
- Reset mid-operation: aborts the block with no output; the stored master key is lost (mkey_reg=0).
- FSM IDLE:
  - in_ready=1.
  - Accept when in_valid & in_ready at a clock edge (edge E0).
  - Selected key k = in_key_load ? in_key : mkey_reg.
  - Registers: state_reg <= in_data ^ k; key_reg <= k; if in_key_load, mkey_reg <= in_key; round_cnt <= 1.
  - Next state RUN.
- FSM RUN:
  - Datapath inputs: in=state_reg, keyin=key_reg, round_num=round_cnt.
  - Each edge: state_reg <= dp.out; key_reg <= dp.keyout.
  - If round_cnt==10: out_data <= dp.out, out_valid <= 1, round_cnt <= 0, next state DONE.
  - Otherwise round_cnt <= round_cnt+1.
  - Inputs are ignored; in_ready=0.
- FSM DONE:
  - out_valid=1; out_data stable.
  - When out_ready is high at an edge: out_valid <= 0, next state IDLE.
  - Stalls indefinitely while out_ready=0; no timeout.
- Latency: out_valid rises after edge E10, i.e. 10 cycles after the acceptance edge. Minimum accept-to-accept spacing is 12 cycles (accept, 10 RUN cycles, 1 DONE handshake cycle).
- in_ready is a registered function of state only; no combinational path from out_ready to in_ready.
- in_valid in RUN/DONE: held off by in_ready=0; the source must hold its data.
- Reuse of the master key (in_key_load=0) before any key load after reset encrypts with the all-zero key. This is legal and not flagged.
- Round 10 omits MixColumns inside the datapath, selected by round_num==10. The controller must drive exactly 1..10 and never 0 during RUN.
- busy = (state != IDLE).

Decomposition:
- Shared package aes_pkg:
  - constants AES_NR=10, AES_DW=128;
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- One sub-module: the existing combinational `round` datapath, instantiated once inside aes_iter_ctrl.
- Controller RTL: FSM, round counter, state/key/master-key registers, output register.

Test Plan:
- FIPS-197 App. B: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, key_load=1, out_ready=1 -> out_valid 10 cycles after accept, out_data=3925841d02dc09fbdc118597196a0b32; round_cnt sequence 1..10 then 0.
- FIPS-197 App. C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Key reuse:
  - load the C.1 key with the C.1 pt and get the C.1 result;
  - then send pt=00112233445566778899aabbccddeeff with key_load=0 and in_key=all-ones -> again 69c4e0d86a7b0430d8cdb78070b4c55a, proving in_key was ignored.
- Backpressure: hold out_ready=0 for 20 cycles after completion -> out_valid and out_data stable, in_ready=0, busy=1; raise out_ready -> next cycle IDLE, in_ready=1.
- Reset mid-round: assert rst while round_cnt=5 -> immediately out_valid=0, round_cnt=0, busy=0, out_data=0; then key_load=0 with pt=0 -> output equals AES-128 with the zero key, 66e94bd4ef8a2c3b884cfa59ca342b2e.
- in_valid held high continuously with out_ready=1 -> accepts spaced exactly 12 cycles apart; no acceptance occurs while busy=1.
